// File: rtl/weight_pkg.sv
// Shared weight definitions for the weight register block and the array
// multipliers that consume its output.
//   WEIGHT_BW_DEFAULT : default width of a stored signed weight
//   weight_t          : signed weight word at the default width
package weight_pkg;

  localparam int unsigned WEIGHT_BW_DEFAULT = 8;

  typedef logic signed [WEIGHT_BW_DEFAULT-1:0] weight_t;

endpackage

// File: rtl/weight_reg_cell.sv
// Signed register cell with load enable and synchronous active-high reset.
// Ports:
//   clk : clock, rising-edge
//   rst : synchronous reset, loads RESET_VALUE
//   en  : load enable, samples d
//   d   : data in
//   q   : registered data out, driven directly from the flop
module weight_reg_cell
  import weight_pkg::*;
#(
  parameter int unsigned                 WIDTH       = WEIGHT_BW_DEFAULT,
  parameter logic signed [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [WIDTH-1:0]  d,
  output logic signed [WIDTH-1:0]  q
);

  logic signed [WIDTH-1:0] q_d;
  logic signed [WIDTH-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/weight_reg_block.sv
// Weight register: holds one signed weight for the multiplier array.
// Optional build macro: WEIGHT_REG_SHADOW_EN adds a double-buffered shadow
// register loaded by we_rl and transferred to weight by swap.
// Ports:
//   clk          : clock, rising-edge
//   rst          : synchronous active-high reset
//   we_rl        : load enable (writes weight, or the shadow in shadow mode)
//   W            : signed weight data to load
//   weight       : registered signed weight
//   weight_valid : weight holds a loaded value since the last reset
//   swap         : (shadow mode) move shadow to weight
//   shadow_valid : (shadow mode) shadow holds an unswapped loaded value
module weight_reg_block
  import weight_pkg::*;
#(
  parameter int unsigned                 WEIGHT_BW   = WEIGHT_BW_DEFAULT,
  parameter logic signed [WEIGHT_BW-1:0] RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we_rl,
  input  logic signed [WEIGHT_BW-1:0]  W,
`ifdef WEIGHT_REG_SHADOW_EN
  input  logic                         swap,
  output logic                         shadow_valid,
`endif
  output logic signed [WEIGHT_BW-1:0]  weight,
  output logic                         weight_valid
);

  logic                        weight_load;
  logic signed [WEIGHT_BW-1:0] weight_src;
  logic                        weight_valid_d;
  logic                        weight_valid_q;

`ifdef WEIGHT_REG_SHADOW_EN
  logic signed [WEIGHT_BW-1:0] shadow;
  logic                        do_swap;
  logic                        shadow_valid_d;
  logic                        shadow_valid_q;

  weight_reg_cell #(
    .WIDTH       (WEIGHT_BW),
    .RESET_VALUE (RESET_VALUE)
  ) u_shadow_cell (
    .clk (clk),
    .rst (rst),
    .en  (we_rl),
    .d   (W),
    .q   (shadow)
  );

  // A swap on an empty shadow is ignored. On a simultaneous load and swap the
  // active cell takes the old shadow while the shadow takes W in the same edge.
  always_comb begin
    do_swap     = swap && shadow_valid_q;
    weight_load = do_swap;
    weight_src  = shadow;
    shadow_valid_d = shadow_valid_q;
    if (do_swap) begin
      shadow_valid_d = 1'b0;
    end
    if (we_rl) begin
      shadow_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_valid_q <= 1'b0;
    end else begin
      shadow_valid_q <= shadow_valid_d;
    end
  end

  assign shadow_valid = shadow_valid_q;
`else
  always_comb begin
    weight_load = we_rl;
    weight_src  = W;
  end
`endif

  weight_reg_cell #(
    .WIDTH       (WEIGHT_BW),
    .RESET_VALUE (RESET_VALUE)
  ) u_weight_cell (
    .clk (clk),
    .rst (rst),
    .en  (weight_load),
    .d   (weight_src),
    .q   (weight)
  );

  // Sticky until reset: set by the first write into the active register.
  always_comb begin
    weight_valid_d = weight_valid_q || weight_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      weight_valid_q <= 1'b0;
    end else begin
      weight_valid_q <= weight_valid_d;
    end
  end

  assign weight_valid = weight_valid_q;

endmodule

// File: tb/tb_weight_reg_block.sv
// Self-checking bench for weight_reg_block (default 8-bit weight, reset 0).
// Covers base mode by default; the shadow sequence is built when
// WEIGHT_REG_SHADOW_EN is defined.
module tb_weight_reg_block;

  logic              clk;
  logic              rst;
  logic              we_rl;
  logic signed [7:0] W;
  logic signed [7:0] weight;
  logic              weight_valid;
`ifdef WEIGHT_REG_SHADOW_EN
  logic              swap;
  logic              shadow_valid;
`endif

  int unsigned checks;
  int unsigned passed;

  weight_reg_block #(
    .WEIGHT_BW   (8),
    .RESET_VALUE (8'sd0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .we_rl        (we_rl),
    .W            (W),
`ifdef WEIGHT_REG_SHADOW_EN
    .swap         (swap),
    .shadow_valid (shadow_valid),
`endif
    .weight       (weight),
    .weight_valid (weight_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       we;
    logic [7:0] w;
    logic [7:0] exp_weight;
    logic       exp_valid;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      passed++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifndef WEIGHT_REG_SHADOW_EN
  vec_t vecs [14];
`endif

  initial begin
    checks = 0;
    passed = 0;
    rst    = 1'b1;
    we_rl  = 1'b0;
    W      = 8'h00;
`ifdef WEIGHT_REG_SHADOW_EN
    swap   = 1'b0;
`endif
    #2;

`ifndef WEIGHT_REG_SHADOW_EN
    //           rst   we    W      weight valid
    vecs[0]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0}; // reset
    vecs[1]  = '{1'b0, 1'b0, 8'h10, 8'h00, 1'b0}; // idle after reset
    vecs[2]  = '{1'b0, 1'b1, 8'h20, 8'h20, 1'b1}; // load 32
    vecs[3]  = '{1'b0, 1'b0, 8'h30, 8'h20, 1'b1}; // hold
    vecs[4]  = '{1'b1, 1'b1, 8'h30, 8'h00, 1'b0}; // reset beats load
    vecs[5]  = '{1'b0, 1'b0, 8'h55, 8'h00, 1'b0}; // holds reset value
    vecs[6]  = '{1'b0, 1'b1, 8'h80, 8'h80, 1'b1}; // -128
    vecs[7]  = '{1'b0, 1'b1, 8'h7F, 8'h7F, 1'b1}; // 127
    vecs[8]  = '{1'b0, 1'b1, 8'h01, 8'h01, 1'b1}; // back-to-back 1
    vecs[9]  = '{1'b0, 1'b1, 8'h02, 8'h02, 1'b1}; // back-to-back 2
    vecs[10] = '{1'b0, 1'b1, 8'h03, 8'h03, 1'b1}; // back-to-back 3
    vecs[11] = '{1'b0, 1'b0, 8'hFF, 8'h03, 1'b1}; // hold
    vecs[12] = '{1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1}; // -1
    vecs[13] = '{1'b0, 1'b1, 8'hA5, 8'hA5, 1'b1}; // mixed bit pattern

    for (int i = 0; i < 14; i++) begin
      rst   = vecs[i].rst;
      we_rl = vecs[i].we;
      W     = vecs[i].w;
      step();
      chk($sformatf("vec%0d_weight", i), weight, vecs[i].exp_weight);
      chk($sformatf("vec%0d_valid", i), {7'd0, weight_valid}, {7'd0, vecs[i].exp_valid});
    end

    // Inputs change between edges: outputs must not move until the next edge.
    rst   = 1'b0;
    we_rl = 1'b1;
    W     = 8'h5A;
    #2;
    chk("no_comb_path", weight, 8'hA5);
    step();
    chk("load_after_edge", weight, 8'h5A);

    // Reset mid-operation discards the value, then a fresh load works.
    rst = 1'b1;
    W   = 8'h66;
    step();
    chk("mid_reset_weight", weight, 8'h00);
    chk("mid_reset_valid", {7'd0, weight_valid}, 8'h00);
    rst = 1'b0;
    W   = 8'h81;
    step();
    chk("reload_weight", weight, 8'h81);
    chk("reload_valid", {7'd0, weight_valid}, 8'h01);
`else
    step();
    rst = 1'b0;
    chk("rst_weight", weight, 8'h00);
    chk("rst_sv", {7'd0, shadow_valid}, 8'h00);

    we_rl = 1'b1; W = 8'h20;
    step();
    chk("shload_weight", weight, 8'h00);
    chk("shload_wv", {7'd0, weight_valid}, 8'h00);
    chk("shload_sv", {7'd0, shadow_valid}, 8'h01);

    we_rl = 1'b0; swap = 1'b1; W = 8'h77;
    step();
    chk("swap_weight", weight, 8'h20);
    chk("swap_wv", {7'd0, weight_valid}, 8'h01);
    chk("swap_sv", {7'd0, shadow_valid}, 8'h00);

    step(); // swap with empty shadow
    chk("empty_swap_weight", weight, 8'h20);
    chk("empty_swap_sv", {7'd0, shadow_valid}, 8'h00);

    swap = 1'b0; we_rl = 1'b1; W = 8'h40;
    step();
    chk("load2_weight", weight, 8'h20);

    swap = 1'b1; W = 8'h50; // load and swap together
    step();
    chk("both_weight", weight, 8'h40);
    chk("both_sv", {7'd0, shadow_valid}, 8'h01);

    we_rl = 1'b0;
    step();
    chk("swap2_weight", weight, 8'h50);
    chk("swap2_sv", {7'd0, shadow_valid}, 8'h00);

    rst = 1'b1; we_rl = 1'b1; swap = 1'b1;
    step();
    chk("rst_dom_weight", weight, 8'h00);
    chk("rst_dom_wv", {7'd0, weight_valid}, 8'h00);
    chk("rst_dom_sv", {7'd0, shadow_valid}, 8'h00);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
